// File: rtl/alu_top.sv
// -----------------------------------------------------------------------------
// alu_top
//   Single-cycle 8-bit ALU with a registered result. An op class from main
//   control and an R-type function field select the operation. The decoded
//   operation code, the result and the four flags are all registered on the
//   rising clock edge, so latency is one cycle. A new operation may start on
//   every cycle.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-high reset (clears all outputs)
//   ina        in   8  operand A (sole operand for NOT, shifts, rotates)
//   inb        in   8  operand B
//   shamt      in   5  shift / rotate amount, 0..31
//   ALUOp      in   2  main-control op class
//   func       in   6  R-type function field (used only when ALUOp = 10)
//   operation  out  4  registered decoded operation code
//   out        out  8  registered result
//   cr         out  1  carry (ADD/SUB only; for SUB 1 means no borrow)
//   zr         out  1  result is zero
//   ng         out  1  result bit 7
//   ov         out  1  signed overflow (ADD/SUB only)
// -----------------------------------------------------------------------------
module alu_top (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ina,
    input  logic [7:0] inb,
    input  logic [4:0] shamt,
    input  logic [1:0] ALUOp,
    input  logic [5:0] func,
    output logic [3:0] operation,
    output logic [7:0] out,
    output logic       cr,
    output logic       zr,
    output logic       ng,
    output logic       ov
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_ROR = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;
    localparam logic [3:0] OP_SLT = 4'b1010;
    localparam logic [3:0] OP_INV = 4'b1111;

    logic [3:0] operation_d, operation_q;
    logic [7:0] out_d, out_q;
    logic       cr_d, cr_q;
    logic       zr_d, zr_q;
    logic       ng_d, ng_q;
    logic       ov_d, ov_q;

    // Shared datapath intermediates
    logic [8:0]  add_sum;
    logic [8:0]  sub_sum;
    logic [7:0]  inb_n;
    logic        big_shift;
    logic [2:0]  rot_amt;
    logic [15:0] ror_wide;
    logic [15:0] rol_wide;
    logic [7:0]  sra_res;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        operation_d = OP_INV;
        case (ALUOp)
            2'b00: operation_d = OP_ADD;
            2'b01: operation_d = OP_SUB;
            2'b11: operation_d = OP_ADD;
            default: begin
                case (func)
                    6'b000010: operation_d = OP_ADD;
                    6'b000011: operation_d = OP_SUB;
                    6'b000100: operation_d = OP_AND;
                    6'b000101: operation_d = OP_OR;
                    6'b000001: operation_d = OP_NOT;
                    6'b111101: operation_d = OP_SLL;
                    6'b111001: operation_d = OP_SRL;
                    6'b111010: operation_d = OP_SRA;
                    6'b111011: operation_d = OP_ROR;
                    6'b111110: operation_d = OP_ROL;
                    6'b001010: operation_d = OP_SLT;
                    default:   operation_d = OP_INV;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        inb_n     = ~inb;
        add_sum   = {1'b0, ina} + {1'b0, inb};
        // Subtraction as A + ~B + 1 so the carry-out reads as "no borrow".
        sub_sum   = {1'b0, ina} + {1'b0, inb_n} + 9'd1;
        // Any amount of 8 or more empties the byte entirely.
        big_shift = (shamt >= 5'd8);
        rot_amt   = shamt[2:0];
        // Rotations via a doubled operand: the wanted byte is a window of it.
        ror_wide  = {ina, ina} >> rot_amt;
        rol_wide  = {ina, ina} << rot_amt;
        sra_res   = big_shift ? {8{ina[7]}} : 8'($signed(ina) >>> rot_amt);
    end

    always_comb begin
        out_d = 8'h00;
        cr_d  = 1'b0;
        ov_d  = 1'b0;
        case (operation_d)
            OP_ADD: begin
                out_d = add_sum[7:0];
                cr_d  = add_sum[8];
                ov_d  = (ina[7] == inb[7]) && (add_sum[7] != ina[7]);
            end
            OP_SUB: begin
                out_d = sub_sum[7:0];
                cr_d  = sub_sum[8];
                ov_d  = (ina[7] != inb[7]) && (sub_sum[7] != ina[7]);
            end
            OP_AND: out_d = ina & inb;
            OP_OR:  out_d = ina | inb;
            OP_NOT: out_d = ~ina;
            OP_SLL: out_d = big_shift ? 8'h00 : (ina << rot_amt);
            OP_SRL: out_d = big_shift ? 8'h00 : (ina >> rot_amt);
            OP_SRA: out_d = sra_res;
            OP_ROR: out_d = ror_wide[7:0];
            OP_ROL: out_d = rol_wide[15:8];
            OP_SLT: out_d = ($signed(ina) < $signed(inb)) ? 8'h01 : 8'h00;
            default: out_d = 8'h00;
        endcase
        zr_d = (out_d == 8'h00);
        ng_d = out_d[7];
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operation_q <= 4'b0000;
            out_q       <= 8'h00;
            cr_q        <= 1'b0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            operation_q <= operation_d;
            out_q       <= out_d;
            cr_q        <= cr_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            ov_q        <= ov_d;
        end
    end

    assign operation = operation_q;
    assign out       = out_q;
    assign cr        = cr_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign ov        = ov_q;

endmodule

// File: tb/tb_alu_top.sv
// -----------------------------------------------------------------------------
// tb_alu_top
//   Self-checking bench for alu_top: directed vectors with literal results,
//   a mid-cycle reset, then randomized operations compared every cycle
//   against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ina = 8'h00;
    logic [7:0] inb = 8'h00;
    logic [4:0] shamt = 5'd0;
    logic [1:0] ALUOp = 2'b00;
    logic [5:0] func = 6'b000000;
    logic [3:0] operation;
    logic [7:0] out;
    logic       cr, zr, ng, ov;

    int tests = 0;
    int fails = 0;

    alu_top dut (
        .clk(clk), .rst(rst), .ina(ina), .inb(inb), .shamt(shamt),
        .ALUOp(ALUOp), .func(func), .operation(operation), .out(out),
        .cr(cr), .zr(zr), .ng(ng), .ov(ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: returns {op[3:0], out[7:0], cr, zr, ng, ov}.
    function automatic logic [15:0] model(input int a, input int b, input int sh,
                                          input int aluop, input int f);
        int op, r, c, v, sa, sb, s, k;
        c = 0; v = 0; r = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        if (aluop == 0 || aluop == 3) op = 0;
        else if (aluop == 1) op = 1;
        else begin
            case (f)
                2: op = 0;   3: op = 1;   4: op = 2;   5: op = 3;
                1: op = 4;   61: op = 5;  57: op = 6;  58: op = 7;
                59: op = 8;  62: op = 9;  10: op = 10;
                default: op = 15;
            endcase
        end
        k = sh % 8;
        case (op)
            0: begin s = a + b; r = s % 256; c = (s > 255);
                     v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin s = a + (255 - b) + 1; r = s % 256; c = (s > 255);
                     v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = 255 - a;
            5: r = (sh >= 8) ? 0 : (a * (1 << sh)) % 256;
            6: r = (sh >= 8) ? 0 : a / (1 << sh);
            7: r = (sa >>> sh) & 255;
            8: r = ((a >> k) | (a << (8 - k))) & 255;
            9: r = ((a << k) | (a >> (8 - k))) & 255;
            10: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        return {op[3:0], r[7:0], c[0], (r == 0), r[7], v[0]};
    endfunction

    // Model state tracks what the registered outputs must hold.
    logic [15:0] exp_q = 16'h0000;
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= 16'h0000;
        else     exp_q <= model(ina, inb, shamt, ALUOp, func);
    end

    // Compare process: outputs are meaningful on every cycle.
    always @(negedge clk) begin
        chk("model", {operation, out, cr, zr, ng, ov}, exp_q);
    end

    task automatic drive(input logic [1:0] op, input logic [5:0] f,
                         input logic [7:0] a, input logic [7:0] b, input logic [4:0] sh);
        ALUOp = op; func = f; ina = a; inb = b; shamt = sh;
    endtask

    // Apply at negedge, check the literal result just after the next posedge.
    task automatic vec(input string name, input logic [1:0] op, input logic [5:0] f,
                       input logic [7:0] a, input logic [7:0] b, input logic [4:0] sh,
                       input logic [7:0] exp_out);
        drive(op, f, a, b, sh);
        @(posedge clk); #1;
        chk(name, out, exp_out);
        @(negedge clk);
    endtask

    initial begin
        #3;
        chk("reset_out", out, 8'h00);
        chk("reset_flags", {operation, cr, zr, ng, ov}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        drive(2'b00, 6'd0, 8'hE0, 8'h40, 5'd0);
        @(posedge clk); #1;
        chk("add_out", out, 8'h20);
        chk("add_flags", {cr, ov, ng, zr}, 4'b1000);
        @(negedge clk);
        drive(2'b01, 6'd0, 8'h88, 8'hC0, 5'd0);
        @(posedge clk); #1;
        chk("sub_out", out, 8'hC8);
        chk("sub_flags", {cr, ov, ng}, 3'b001);
        chk("sub_op", operation, 4'b0001);
        @(negedge clk);

        vec("and",     2'b10, 6'b000100, 8'hF0, 8'h62, 5'd0, 8'h60);
        vec("or",      2'b10, 6'b000101, 8'h60, 8'h06, 5'd0, 8'h66);
        vec("not_b00", 2'b10, 6'b000001, 8'hF0, 8'h00, 5'd0, 8'h0F);
        vec("not_bcc", 2'b10, 6'b000001, 8'hF0, 8'hCC, 5'd0, 8'h0F);
        vec("sll0",    2'b10, 6'b111101, 8'h0F, 8'h00, 5'd0, 8'h0F);
        vec("sll2",    2'b10, 6'b111101, 8'h0F, 8'h00, 5'd2, 8'h3C);
        vec("srl3",    2'b10, 6'b111001, 8'h88, 8'h00, 5'd3, 8'h11);
        vec("sra2",    2'b10, 6'b111010, 8'h88, 8'h00, 5'd2, 8'hE2);
        vec("sra9",    2'b10, 6'b111010, 8'h88, 8'h00, 5'd9, 8'hFF);
        vec("ror4",    2'b10, 6'b111011, 8'h01, 8'h00, 5'd4, 8'h10);
        vec("rol3",    2'b10, 6'b111110, 8'h01, 8'h00, 5'd3, 8'h08);
        vec("rol11",   2'b10, 6'b111110, 8'h01, 8'h00, 5'd11, 8'h08);
        vec("slt_lt",  2'b10, 6'b001010, 8'h92, 8'h95, 5'd0, 8'h01);
        vec("slt_ge",  2'b10, 6'b001010, 8'h7F, 8'h80, 5'd0, 8'h00);
        drive(2'b10, 6'b001010, 8'h2D, 8'h2C, 5'd0);
        @(posedge clk); #1;
        chk("slt_eq_zr", {out, zr}, {8'h00, 1'b1});
        @(negedge clk);

        // Reset between edges while an ADD result is held.
        drive(2'b00, 6'd0, 8'h7F, 8'h01, 5'd0);
        @(posedge clk); #1;
        chk("pre_rst_add", {out, ov, ng}, {8'h80, 1'b1, 1'b1});
        #1 rst = 1'b1;
        #1;
        chk("async_rst", {operation, out, cr, zr, ng, ov}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b10, 6'b111111, 8'h55, 8'hAA, 5'd3);
        @(posedge clk); #1;
        chk("invalid", {operation, out, cr, zr, ng, ov}, {4'hF, 8'h00, 4'b0100});
        @(negedge clk);

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 2000; i++) begin
            logic [5:0] f;
            case ($urandom_range(0, 11))
                0: f = 6'b000010;  1: f = 6'b000011;  2: f = 6'b000100;
                3: f = 6'b000101;  4: f = 6'b000001;  5: f = 6'b111101;
                6: f = 6'b111001;  7: f = 6'b111010;  8: f = 6'b111011;
                9: f = 6'b111110;  10: f = 6'b001010;
                default: f = 6'($urandom);
            endcase
            drive(2'($urandom), f, 8'($urandom), 8'($urandom), 5'($urandom));
            if (i % 500 == 250) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_top.md
ALU_TOP -- requirements
Module: alu_top

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock; all outputs registered on it.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 ina  input  8  operand A; the only operand for NOT and for all shifts and rotates.
REQ-005 inb  input  8  operand B; ignored for NOT, shifts and rotates.
REQ-006 shamt  input  5  shift/rotate amount, 0..31.
REQ-007 ALUOp  input  2  main-control op class.
REQ-008 func  input  6  R-type function field.
REQ-009 operation  output  4  registered decoded operation code.
REQ-010 out  output  8  registered result.
REQ-011 cr, zr, ng, ov  output  1 each  registered carry, zero, negative and overflow flags.

Function
REQ-012 Operation codes SHALL be: ADD 0000, SUB 0001, AND 0010, OR 0011, NOT 0100, SLL 0101, SRL 0110, SRA 0111, ROR 1000, ROL 1001, SLT 1010, INVALID 1111.
REQ-013 Decode SHALL be: ALUOp 00 -> ADD; 01 -> SUB; 11 -> ADD; func is ignored for 00, 01 and 11.
REQ-014 For ALUOp 10, func SHALL decode as:
- 000010 ADD; 000011 SUB
- 000100 AND; 000101 OR; 000001 NOT
- 111101 SLL; 111001 SRL; 111010 SRA
- 111011 ROR; 111110 ROL; 001010 SLT
- any other value -> INVALID
REQ-015 ADD: out = (ina+inb)[7:0]; cr = bit-8 carry-out; ov = signed overflow.
REQ-016 SUB: out = ina-inb, computed as ina+~inb+1; cr = carry-out of that sum (1 = no borrow); ov = signed overflow.
REQ-017 Logic ops SHALL be: AND = ina&inb; OR = ina|inb; NOT = ~ina.
REQ-018 Shift behaviour:
- SLL: ina<<shamt.
- SRL: zero-fill right shift.
- SRA: sign-fill right shift.
- shamt=0 leaves ina unchanged.
- shamt>=8: SLL/SRL give 0x00; SRA gives 0x00 or 0xFF per ina[7].
REQ-019 ROR/ROL SHALL rotate ina by shamt mod 8.
REQ-020 SLT SHALL output 0x01 if ina < inb as signed two's complement, else 0x00.
REQ-021 cr and ov SHALL be 0 for every operation except ADD and SUB.
REQ-022 Flag rules for all operations: zr = (out==0); ng = out[7].
REQ-023 INVALID SHALL give out=0x00, zr=1, cr=ng=ov=0.
REQ-024 Inputs SHALL be sampled on each rising clk edge; out, the flags and operation update at that edge (latency 1 cycle, no handshake, a new operation every cycle).

Reset
REQ-025 While rst=1, out=0x00, operation=0000 and cr=zr=ng=ov=0, taking effect immediately without waiting for clk.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result; the first edge after rst falls produces a result from the inputs present at that edge.

Verification
REQ-027 ALUOp 00, ina E0, inb 40 -> out 20, cr1 ov0 ng0 zr0; ALUOp 01, ina 88, inb C0 -> out C8, cr0 ov0 ng1.
REQ-028 ALUOp 10 logic ops:
- func 000100, F0&62 -> 60.
- func 000101, 60|06 -> 66.
- func 000001, ina F0 -> 0F for both inb 00 and inb CC.
REQ-029 Shifts on ALUOp 10:
- SLL 0F, shamt 0 -> 0F; shamt 2 -> 3C.
- SRL 88, shamt 3 -> 11.
- SRA 88, shamt 2 -> E2, ng1.
- SRA 88, shamt 9 -> FF.
REQ-030 Rotates on ALUOp 10:
- ROR 01, shamt 4 -> 10.
- ROL 01, shamt 3 -> 08.
- ROL 01, shamt 11 -> 08.
REQ-031 SLT on ALUOp 10:
- 92 vs 95 -> 01.
- 2D vs 2C -> 00, zr1.
- 7F vs 80 -> 00.
REQ-032 Assert rst between clock edges during an ADD -> all outputs 0 immediately; func 111111 with ALUOp 10 -> operation 1111, out 00, zr1.
